systolic_skew_feeder: RTL



---
 rtl/systolic_pkg.sv | 22 ++
 rtl/skew_delay_line.sv | 32 +++
 rtl/systolic_skew_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array: lane width default, feeder state
// encoding, PE data-type codes and the feeder flush-length helper.
package systolic_pkg;

  localparam int unsigned LANE_W_DEF = 32;

  typedef logic [2:0] data_type_t;
  localparam data_type_t DT_INT8 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  // Skew drain (n-1) plus array traversal (n-1); at least 1 keeps counter widths legal.
  function automatic int unsigned flush_cycles(input int unsigned n);
    return (n > 1) ? (2 * n - 2) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain with synchronous reset; carries one lane's
// {valid, A, B} word through DEPTH registers unchanged.
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the systolic array: skews lane i by i cycles, flushes the
// array with zeros after the last beat, then pulses done. SKEW_FEEDER_CNT_EN adds beat_cnt.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*LANE_W-1:0] a_in,
  input  logic [N*LANE_W-1:0] b_in,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [N*LANE_W-1:0] row_out,
  output logic [N*LANE_W-1:0] col_out,
  output logic [N-1:0]        lane_vld,
  output logic                busy,
  output logic                done
`ifdef SKEW_FEEDER_CNT_EN
  ,
  output logic [15:0]         beat_cnt
`endif
);

  localparam int unsigned FLUSH_LEN = flush_cycles(N);
  localparam int unsigned CNT_W     = $clog2(FLUSH_LEN + 1);
  localparam int unsigned DL_W      = 2 * LANE_W + 1;

  feeder_state_e    r_state;
  feeder_state_e    w_state_nxt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_FEED);
  assign w_accept = in_valid & in_ready;

  // Next-state logic; the flush counter is loaded on the last beat and runs down to zero.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    unique case (r_state)
      ST_IDLE, ST_FEED: begin
        if (w_accept) begin
          if (in_last) begin
            if (N == 1) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt     = ST_FLUSH;
              w_flush_cnt_nxt = CNT_W'(FLUSH_LEN - 1);
            end
          end else begin
            w_state_nxt = ST_FEED;
          end
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // Lane i gets i+1 registers; bubbles and flush slots enter as all-zero words.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DL_W-1:0] w_d;
    logic [DL_W-1:0] w_q;

    assign w_d = w_accept ? {1'b1, a_in[gi*LANE_W +: LANE_W], b_in[gi*LANE_W +: LANE_W]}
                          : '0;

    skew_delay_line #(
      .DEPTH (gi + 1),
      .W     (DL_W)
    ) u_delay (
      .clk (clk),
      .rst (rst),
      .i_d (w_d),
      .o_q (w_q)
    );

    assign lane_vld[gi]                   = w_q[DL_W-1];
    assign row_out[gi*LANE_W +: LANE_W]   = w_q[2*LANE_W-1 -: LANE_W];
    assign col_out[gi*LANE_W +: LANE_W]   = w_q[LANE_W-1:0];
  end

`ifdef SKEW_FEEDER_CNT_EN
  logic [15:0] r_beat_cnt;

  // First beat of a pass restarts the count; later beats saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_beat_cnt <= 16'd1;
      end else if (r_beat_cnt != 16'hFFFF) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule
